// File: rtl/branch_pkg.sv
// Shared types and constants for the branch predictor / mispredict recovery block.
package branch_pkg;

    localparam logic [6:0] B_TYPE = 7'b1100011;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_ALLOC = 2'b10;

    // Entry fields are sized for the widest supported PC; narrower PCs zero-extend.
    localparam int BP_MAX_AWIDTH = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } bp_state_t;

    typedef struct packed {
        logic                     valid;
        logic [BP_MAX_AWIDTH-1:0] tag;
        logic [BP_MAX_AWIDTH-1:0] target;
        logic [1:0]               ctr;
    } btb_entry_t;

    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken && ctr != 2'b11) begin
            res = ctr + 2'b01;
        end else if (!taken && ctr != 2'b00) begin
            res = ctr - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: two async read ports, one write port, async clear of valid/counters.
module btb_table
    import branch_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX     = 6,
    parameter int TAG_W   = 24,
    parameter int AWIDTH  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX-1:0]   rd_a_idx_i,
    output btb_entry_t       rd_a_o,
    input  logic [IDX-1:0]   rd_b_idx_i,
    output btb_entry_t       rd_b_o,
    input  logic             we_i,
    input  logic [IDX-1:0]   wr_idx_i,
    input  btb_entry_t       wr_entry_i
);

    logic [ENTRIES-1:0]      valid_vec;
    logic [ENTRIES-1:0][1:0] ctr_vec;
    logic [TAG_W-1:0]        tag_mem    [ENTRIES];
    logic [AWIDTH-1:0]       target_mem [ENTRIES];

    // Valid bits and counters need the async clear, so they live in per-entry flops.
    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic       valid_q;
            logic [1:0] ctr_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    ctr_q   <= CTR_RESET;
                end else if (we_i && wr_idx_i == IDX'(gi)) begin
                    valid_q <= wr_entry_i.valid;
                    ctr_q   <= wr_entry_i.ctr;
                end
            end

            assign valid_vec[gi] = valid_q;
            assign ctr_vec[gi]   = ctr_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_mem[wr_idx_i]    <= wr_entry_i.tag[TAG_W-1:0];
            target_mem[wr_idx_i] <= wr_entry_i.target[AWIDTH-1:0];
        end
    end

    always_comb begin
        rd_a_o        = '0;
        rd_a_o.valid  = valid_vec[rd_a_idx_i];
        rd_a_o.tag    = BP_MAX_AWIDTH'(tag_mem[rd_a_idx_i]);
        rd_a_o.target = BP_MAX_AWIDTH'(target_mem[rd_a_idx_i]);
        rd_a_o.ctr    = ctr_vec[rd_a_idx_i];

        rd_b_o        = '0;
        rd_b_o.valid  = valid_vec[rd_b_idx_i];
        rd_b_o.tag    = BP_MAX_AWIDTH'(tag_mem[rd_b_idx_i]);
        rd_b_o.target = BP_MAX_AWIDTH'(target_mem[rd_b_idx_i]);
        rd_b_o.ctr    = ctr_vec[rd_b_idx_i];
    end

    logic unused_wr;
    assign unused_wr = ^wr_entry_i;

endmodule

// File: rtl/branch_predictor_ctrl.sv
// Fetch-side BTB prediction plus execute-side branch resolution, redirect and flush sequencing.
module branch_predictor_ctrl
    import branch_pkg::*;
#(
    parameter int AWIDTH      = 32,
    parameter int BTB_ENTRIES = 64,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AWIDTH-1:0] f_pc_i,
    output logic              f_pred_taken_o,
    output logic [AWIDTH-1:0] f_pred_target_o,
    input  logic              e_valid_i,
    input  logic              e_stall_i,
    input  logic [6:0]        e_opcode_i,
    input  logic [2:0]        e_funct3_i,
    input  logic [AWIDTH-1:0] e_pc_i,
    input  logic [AWIDTH-1:0] e_target_i,
    input  logic              e_breq_i,
    input  logic              e_brlt_i,
    input  logic              e_pred_taken_i,
    input  logic [AWIDTH-1:0] e_pred_target_i,
    output logic              redirect_o,
    output logic [AWIDTH-1:0] redirect_pc_o,
    output logic              flush_o,
    output logic [31:0]       br_count_o,
    output logic [31:0]       mispred_count_o
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = AWIDTH - IDX - 2;
    localparam int CNT_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

    bp_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              redirect_q, redirect_d;
    logic [AWIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic [31:0]       br_cnt_q, br_cnt_d;
    logic [31:0]       mis_cnt_q, mis_cnt_d;

    btb_entry_t        f_rd, e_rd, btb_wdata;
    logic              f_hit, e_hit;
    logic [IDX-1:0]    f_idx, e_idx;
    logic [TAG_W-1:0]  f_tag, e_tag;
    logic              f3_ok, actual_taken, resolve, mispred, btb_we;

    assign f_idx = f_pc_i[IDX+1:2];
    assign f_tag = f_pc_i[AWIDTH-1:IDX+2];
    assign e_idx = e_pc_i[IDX+1:2];
    assign e_tag = e_pc_i[AWIDTH-1:IDX+2];

    btb_table #(
        .ENTRIES (BTB_ENTRIES),
        .IDX     (IDX),
        .TAG_W   (TAG_W),
        .AWIDTH  (AWIDTH)
    ) u_btb (
        .clk        (clk),
        .reset      (reset),
        .rd_a_idx_i (f_idx),
        .rd_a_o     (f_rd),
        .rd_b_idx_i (e_idx),
        .rd_b_o     (e_rd),
        .we_i       (btb_we),
        .wr_idx_i   (e_idx),
        .wr_entry_i (btb_wdata)
    );

    assign f_hit           = f_rd.valid && (f_rd.tag[TAG_W-1:0] == f_tag);
    assign f_pred_taken_o  = f_hit && f_rd.ctr[1];
    assign f_pred_target_o = f_hit ? f_rd.target[AWIDTH-1:0] : '0;
    assign e_hit           = e_rd.valid && (e_rd.tag[TAG_W-1:0] == e_tag);

    always_comb begin
        f3_ok        = 1'b1;
        actual_taken = 1'b0;
        case (e_funct3_i)
            F3_BEQ:           actual_taken = e_breq_i;
            F3_BNE:           actual_taken = !e_breq_i;
            F3_BLT, F3_BLTU:  actual_taken = e_brlt_i;
            F3_BGE, F3_BGEU:  actual_taken = !e_brlt_i;
            default:          f3_ok = 1'b0;
        endcase
    end

    // Wrong-path instructions in FLUSH never resolve, so the table and counts stay clean.
    assign resolve = (state_q == IDLE) && e_valid_i && !e_stall_i &&
                     (e_opcode_i == B_TYPE) && f3_ok;
    assign mispred = (e_pred_taken_i != actual_taken) ||
                     (e_pred_taken_i && actual_taken && (e_pred_target_i != e_target_i));
    assign btb_we  = resolve && (e_hit || actual_taken);

    always_comb begin
        btb_wdata        = '0;
        btb_wdata.valid  = 1'b1;
        btb_wdata.tag    = BP_MAX_AWIDTH'(e_tag);
        btb_wdata.target = BP_MAX_AWIDTH'(actual_taken ? e_target_i : e_rd.target[AWIDTH-1:0]);
        btb_wdata.ctr    = e_hit ? ctr_step(e_rd.ctr, actual_taken) : CTR_ALLOC;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        br_cnt_d      = br_cnt_q;
        mis_cnt_d     = mis_cnt_q;
        case (state_q)
            IDLE: begin
                if (resolve) begin
                    br_cnt_d = br_cnt_q + 32'd1;
                    if (mispred) begin
                        mis_cnt_d     = mis_cnt_q + 32'd1;
                        redirect_d    = 1'b1;
                        redirect_pc_d = actual_taken ? e_target_i : (e_pc_i + AWIDTH'(4));
                        state_d       = FLUSH;
                        cnt_d         = CNT_W'(FLUSH_DEPTH - 1);
                    end
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            br_cnt_q      <= '0;
            mis_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            br_cnt_q      <= br_cnt_d;
            mis_cnt_q     <= mis_cnt_d;
        end
    end

    assign flush_o         = (state_q == FLUSH);
    assign redirect_o      = redirect_q;
    assign redirect_pc_o   = redirect_pc_q;
    assign br_count_o      = br_cnt_q;
    assign mispred_count_o = mis_cnt_q;

    logic unused_bits;
    assign unused_bits = ^{f_pc_i[1:0], e_pc_i[1:0], f_rd, e_rd};

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Directed test of branch_predictor_ctrl: prediction, resolution, redirect/flush, aliasing, reset.
module tb_branch_predictor_ctrl;

    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] f_pc_i;
    logic        f_pred_taken_o;
    logic [31:0] f_pred_target_o;
    logic        e_valid_i, e_stall_i;
    logic [6:0]  e_opcode_i;
    logic [2:0]  e_funct3_i;
    logic [31:0] e_pc_i, e_target_i, e_pred_target_i;
    logic        e_breq_i, e_brlt_i, e_pred_taken_i;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        flush_o;
    logic [31:0] br_count_o, mispred_count_o;

    int n_compared = 0;
    int n_mismatch = 0;

    always #5 clk = ~clk;

    branch_predictor_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .f_pc_i          (f_pc_i),
        .f_pred_taken_o  (f_pred_taken_o),
        .f_pred_target_o (f_pred_target_o),
        .e_valid_i       (e_valid_i),
        .e_stall_i       (e_stall_i),
        .e_opcode_i      (e_opcode_i),
        .e_funct3_i      (e_funct3_i),
        .e_pc_i          (e_pc_i),
        .e_target_i      (e_target_i),
        .e_breq_i        (e_breq_i),
        .e_brlt_i        (e_brlt_i),
        .e_pred_taken_i  (e_pred_taken_i),
        .e_pred_target_i (e_pred_target_i),
        .redirect_o      (redirect_o),
        .redirect_pc_o   (redirect_pc_o),
        .flush_o         (flush_o),
        .br_count_o      (br_count_o),
        .mispred_count_o (mispred_count_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic breq, input logic brlt, input logic pt,
                          input logic [31:0] ptgt);
        e_valid_i       = 1'b1;
        e_opcode_i      = OP_B;
        e_funct3_i      = f3;
        e_pc_i          = pc;
        e_target_i      = tgt;
        e_breq_i        = breq;
        e_brlt_i        = brlt;
        e_pred_taken_i  = pt;
        e_pred_target_i = ptgt;
    endtask

    task automatic clr_br();
        e_valid_i = 1'b0;
    endtask

    task automatic fetch_check(input string tag, input logic [31:0] pc,
                               input logic exp_taken, input logic [31:0] exp_tgt);
        f_pc_i = pc;
        #1;
        check_eq({tag, "_taken"}, {31'd0, f_pred_taken_o}, {31'd0, exp_taken});
        check_eq({tag, "_tgt"}, f_pred_target_o, exp_tgt);
    endtask

    task automatic state_check(input string tag, input logic exp_redir, input logic exp_flush,
                               input logic [31:0] exp_br, input logic [31:0] exp_mis);
        check_eq({tag, "_redirect"}, {31'd0, redirect_o}, {31'd0, exp_redir});
        check_eq({tag, "_flush"}, {31'd0, flush_o}, {31'd0, exp_flush});
        check_eq({tag, "_br"}, br_count_o, exp_br);
        check_eq({tag, "_mis"}, mispred_count_o, exp_mis);
    endtask

    initial begin
        reset = 1'b1;
        f_pc_i = 32'h100;
        e_stall_i = 1'b0;
        set_br(BEQ, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        clr_br();
        #2;
        fetch_check("rst_fetch", 32'h100, 1'b0, 32'h0);
        state_check("rst", 1'b0, 1'b0, 32'd0, 32'd0);
        check_eq("rst_rpc", redirect_pc_o, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // BEQ taken, predicted not-taken: allocate + redirect to target.
        set_br(BEQ, 32'h100, 32'h80, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        clr_br();
        state_check("beq", 1'b1, 1'b1, 32'd1, 32'd1);
        check_eq("beq_rpc", redirect_pc_o, 32'h80);
        fetch_check("beq_fetch", 32'h100, 1'b1, 32'h80);
        tick();
        state_check("beq_f2", 1'b0, 1'b1, 32'd1, 32'd1);
        check_eq("beq_rpc_hold", redirect_pc_o, 32'h80);
        tick();
        state_check("beq_idle", 1'b0, 1'b0, 32'd1, 32'd1);

        // BNE not taken, predicted taken: redirect to pc+4, counter 2->1.
        set_br(BNE, 32'h100, 32'h80, 1'b1, 1'b0, 1'b1, 32'h80);
        tick();
        clr_br();
        state_check("bne", 1'b1, 1'b1, 32'd2, 32'd2);
        check_eq("bne_rpc", redirect_pc_o, 32'h104);
        fetch_check("bne_fetch", 32'h100, 1'b0, 32'h80);
        tick();
        tick();
        check_eq("bne_idle_flush", {31'd0, flush_o}, 32'd0);

        // BLT at 0x200 (aliases 0x100) taken three times, correctly predicted.
        for (int i = 0; i < 3; i++) begin
            set_br(BLT, 32'h200, 32'h300, 1'b0, 1'b1, 1'b1, 32'h300);
            tick();
            check_eq($sformatf("blt%0d_redirect", i), {31'd0, redirect_o}, 32'd0);
            check_eq($sformatf("blt%0d_flush", i), {31'd0, flush_o}, 32'd0);
            fetch_check($sformatf("blt%0d_fetch", i), 32'h200, 1'b1, 32'h300);
        end
        clr_br();
        state_check("blt", 1'b0, 1'b0, 32'd5, 32'd2);
        fetch_check("evicted_100", 32'h100, 1'b0, 32'h0);

        // Stalled mispredicting BGEU is ignored.
        e_stall_i = 1'b1;
        set_br(BGEU, 32'h304, 32'h380, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        e_stall_i = 1'b0;
        clr_br();
        state_check("stall", 1'b0, 1'b0, 32'd5, 32'd2);

        // Undefined funct3 is not a branch.
        set_br(3'b010, 32'h304, 32'h380, 1'b1, 1'b1, 1'b1, 32'h999);
        tick();
        clr_br();
        state_check("f3_010", 1'b0, 1'b0, 32'd5, 32'd2);

        // BLT not taken after saturation: mispredict, counter 3->2 still predicts taken.
        set_br(BLT, 32'h200, 32'h300, 1'b0, 1'b0, 1'b1, 32'h300);
        tick();
        state_check("blt_nt", 1'b1, 1'b1, 32'd6, 32'd3);
        check_eq("blt_nt_rpc", redirect_pc_o, 32'h204);
        fetch_check("blt_nt_fetch", 32'h200, 1'b1, 32'h300);

        // Mispredicting BGEU held through FLUSH is ignored, then resolves once in IDLE.
        set_br(BGEU, 32'h304, 32'h380, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        state_check("bgeu_f2", 1'b0, 1'b1, 32'd6, 32'd3);
        tick();
        state_check("bgeu_idle", 1'b0, 1'b0, 32'd6, 32'd3);
        check_eq("bgeu_rpc_hold", redirect_pc_o, 32'h204);
        tick();
        clr_br();
        state_check("bgeu_res", 1'b1, 1'b1, 32'd7, 32'd4);
        check_eq("bgeu_rpc", redirect_pc_o, 32'h380);
        tick();
        tick();
        check_eq("bgeu_done_flush", {31'd0, flush_o}, 32'd0);

        // BLTU not taken on a miss: correct, no allocation.
        set_br(BLTU, 32'h400, 32'h480, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        clr_br();
        state_check("bltu", 1'b0, 1'b0, 32'd8, 32'd4);
        fetch_check("bltu_fetch", 32'h400, 1'b0, 32'h0);
        fetch_check("keep_200", 32'h200, 1'b1, 32'h300);

        // Reset asserted mid-FLUSH clears everything immediately.
        set_br(BEQ, 32'h500, 32'h580, 1'b0, 1'b0, 1'b1, 32'h580);
        tick();
        clr_br();
        state_check("pre_rst", 1'b1, 1'b1, 32'd9, 32'd5);
        check_eq("pre_rst_rpc", redirect_pc_o, 32'h504);
        #2;
        reset = 1'b1;
        #1;
        state_check("mid_rst", 1'b0, 1'b0, 32'd0, 32'd0);
        check_eq("mid_rst_rpc", redirect_pc_o, 32'h0);
        fetch_check("mid_rst_fetch", 32'h200, 1'b0, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        check_eq("post_rst_flush", {31'd0, flush_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
